// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - ALU op codes of the memory instructions the unit recognises
//   - exception codes reported on mem_excepttype
//   - FSM state encodings and the packed state/debug record
//   - small op classification helpers
package mem_lsu_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] EXCEPT_NONE = 2'b00;
    localparam logic [1:0] EXCEPT_ADEL = 2'b01;
    localparam logic [1:0] EXCEPT_ADES = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // All sequential state of the unit in one record, so a checker can bind
    // to the FSM state and the captured load word through a single signal.
    typedef struct packed {
        logic [2:0]  state;
        logic [31:0] rdata_buf;
    } lsu_state_t;

    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[0];
            EXE_LW_OP, EXE_SW_OP:             return |a;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_ldfmt.sv
// mem_ldfmt: combinational load-data extraction.
//   aluop_i  in  8   load op code (non-load ops pass the word through)
//   addr_i   in  2   byte offset within the word
//   word_i   in  32  raw response word (little-endian lanes)
//   data_o   out 32  byte/half selected and sign- or zero-extended
module mem_ldfmt
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
    end

    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = word_i;
        case (aluop_i)
            EXE_LB_OP:  data_o = {{24{byte_sel[7]}}, byte_sel};
            EXE_LBU_OP: data_o = {24'd0, byte_sel};
            EXE_LH_OP:  data_o = {{16{half_sel[15]}}, half_sel};
            EXE_LHU_OP: data_o = {16'd0, half_sel};
            default:    data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Consumes the EX/MEM bundle, runs the data-SRAM request/response handshake,
// formats load data and produces the bundle latched by MEM/WB.
//   clk, rst                  clock, asynchronous active-low reset
//   stall[5:0], flush         pipeline control (stall[4] = MEM held)
//   mem_*_i, wd_i.. cp0_*_i   EX/MEM bundle
//   data_req/wr/wstrb/addr/wdata  out  SRAM request channel
//   data_addr_ok/data_ok/rdata    in   SRAM accept / response
//   stallreq_mem              out  hold the pipeline while an access is open
//   mem_excepttype/badvaddr   out  AdEL/AdES reporting
//   mem_* / mem2wb_pc         out  bundle to MEM/WB
//
// Handshake: a request is transferred on a cycle where data_req and
// data_addr_ok are both high; address, strobes and data hold steady while
// data_req waits for data_addr_ok. A response is transferred on a cycle with
// data_data_ok high; it is only taken in WAIT or DRAIN, so at most one request
// is ever outstanding.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] mem_pc_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_addr_i,
    input  logic [31:0] cp0_data_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stallreq_mem,
    output logic [1:0]  mem_excepttype,
    output logic [31:0] mem_badvaddr,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_cp0_reg_we,
    output logic [4:0]  mem_cp0_reg_write_addr,
    output logic [31:0] mem_cp0_reg_data,
    output logic [31:0] mem2wb_pc
);

    lsu_state_t lsu_q, lsu_d;

    logic        is_ld, is_st, is_mem, fault, can_issue;
    logic        req_raw, stall_raw;
    logic [31:0] pa, ld_data;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    assign is_ld     = is_load_op(mem_aluop_i);
    assign is_st     = is_store_op(mem_aluop_i);
    assign is_mem    = is_ld | is_st;
    assign fault     = is_mem & is_misaligned(mem_aluop_i, mem_addr_i[1:0]);
    assign can_issue = is_mem & ~fault & ~flush;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB.
    assign pa = (MAP_KSEG && mem_addr_i[31:30] == 2'b10) ? {3'b000, mem_addr_i[28:0]}
                                                         : mem_addr_i;

    always_comb begin
        lsu_d     = lsu_q;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        case (lsu_q.state)
            ST_IDLE: begin
                if (can_issue) begin
                    req_raw = 1'b1;
                    if (data_addr_ok) begin
                        lsu_d.state = ST_WAIT;
                    end else begin
                        stall_raw   = 1'b1;
                        lsu_d.state = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_raw = 1'b1;
                // Withdraw the request on flush so it can never be accepted
                // after the instruction has been killed.
                req_raw = ~flush;
                if (flush)             lsu_d.state = ST_IDLE;
                else if (data_addr_ok) lsu_d.state = ST_WAIT;
            end
            ST_WAIT: begin
                stall_raw = 1'b1;
                if (data_data_ok) begin
                    if (flush) begin
                        lsu_d.state = ST_IDLE;
                    end else begin
                        lsu_d.state     = ST_DONE;
                        lsu_d.rdata_buf = data_rdata;
                    end
                end else if (flush) begin
                    lsu_d.state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A killed access still owns the bus until its response returns.
                stall_raw = 1'b1;
                if (data_data_ok) lsu_d.state = ST_IDLE;
            end
            ST_DONE: begin
                if (flush || !stall[4]) lsu_d.state = ST_IDLE;
            end
            default: lsu_d.state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsu_q.state     <= ST_IDLE;
            lsu_q.rdata_buf <= '0;
        end else begin
            lsu_q <= lsu_d;
        end
    end

    // Keep the bus and the pipeline quiet while reset is held, even though
    // IDLE would otherwise issue for a memory op sitting in EX/MEM.
    assign data_req     = req_raw & rst;
    assign stallreq_mem = stall_raw & rst;

    assign data_wr   = is_st;
    assign data_addr = pa & 32'hFFFF_FFFC;

    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = mem_reg2_i;
        case (mem_aluop_i)
            EXE_SB_OP: begin
                data_wstrb = 4'b0001 << mem_addr_i[1:0];
                data_wdata = {4{mem_reg2_i[7:0]}};
            end
            EXE_SH_OP: begin
                data_wstrb = 4'b0011 << {mem_addr_i[1], 1'b0};
                data_wdata = {2{mem_reg2_i[15:0]}};
            end
            EXE_SW_OP: begin
                data_wstrb = 4'b1111;
                data_wdata = mem_reg2_i;
            end
            default: begin
                data_wstrb = 4'b0000;
                data_wdata = mem_reg2_i;
            end
        endcase
    end

    mem_ldfmt u_ldfmt (
        .aluop_i (mem_aluop_i),
        .addr_i  (mem_addr_i[1:0]),
        .word_i  (lsu_q.rdata_buf),
        .data_o  (ld_data)
    );

    assign mem_excepttype = !fault ? EXCEPT_NONE : (is_st ? EXCEPT_ADES : EXCEPT_ADEL);
    assign mem_badvaddr   = fault ? mem_addr_i : 32'd0;

    assign mem_wd                 = wd_i;
    assign mem_wreg               = wreg_i & ~fault;
    assign mem_wdata              = (is_ld && lsu_q.state == ST_DONE) ? ld_data : wdata_i;
    assign mem_whilo              = whilo_i;
    assign mem_hi                 = hi_i;
    assign mem_lo                 = lo_i;
    assign mem_cp0_reg_we         = cp0_we_i;
    assign mem_cp0_reg_write_addr = cp0_addr_i;
    assign mem_cp0_reg_data       = cp0_data_i;
    assign mem2wb_pc              = mem_pc_i;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    localparam logic [7:0] OP_LB  = 8'hE0, OP_LBU = 8'hE4, OP_LH = 8'hE1, OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3, OP_SB  = 8'hE8, OP_SH = 8'hE9, OP_SW  = 8'hEB;
    localparam logic [7:0] OP_OR  = 8'h25, OP_NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] mem_pc_i, mem_addr_i, mem_reg2_i, wdata_i, hi_i, lo_i, cp0_data_i;
    logic [7:0]  mem_aluop_i;
    logic [4:0]  wd_i, cp0_addr_i;
    logic        wreg_i, whilo_i, cp0_we_i;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, stallreq_mem;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata, mem_badvaddr;
    logic [1:0]  mem_excepttype;
    logic [4:0]  mem_wd, mem_cp0_reg_write_addr;
    logic        mem_wreg, mem_whilo, mem_cp0_reg_we;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_cp0_reg_data, mem2wb_pc;

    mem_lsu #(.MAP_KSEG(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_pc_i(mem_pc_i), .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i),
        .mem_reg2_i(mem_reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .cp0_we_i(cp0_we_i), .cp0_addr_i(cp0_addr_i), .cp0_data_i(cp0_data_i),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stallreq_mem(stallreq_mem), .mem_excepttype(mem_excepttype), .mem_badvaddr(mem_badvaddr),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
        .mem_cp0_reg_data(mem_cp0_reg_data), .mem2wb_pc(mem2wb_pc)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          checks = 0;
    int          errors = 0;
    int          seq = 0;
    bit          cmp_en = 1'b0;
    bit          model_loaded = 1'b0;
    logic [31:0] model_word = '0;
    logic [31:0] first_addr, first_wdata;
    logic [3:0]  first_strb;
    logic        first_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] m_phys(input logic [31:0] va);
        logic [31:0] pa;
        pa = (va >= 32'h8000_0000 && va < 32'hC000_0000) ? va % 32'h2000_0000 : va;
        return pa - (pa % 4);
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
        logic [31:0] w;
        w = word >> (8 * (addr % 4));
        case (op)
            OP_LB:   return w[7]  ? (w % 256)   + 32'hFFFF_FF00 : w % 256;
            OP_LBU:  return w % 256;
            OP_LH:   return w[15] ? (w % 65536) + 32'hFFFF_0000 : w % 65536;
            OP_LHU:  return w % 65536;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [7:0] op, input logic [31:0] addr);
        int s;
        s = m_size(op);
        return 4'(((1 << s) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] reg2);
        case (m_size(op))
            1:       return (reg2 % 256) * 32'h0101_0101;
            2:       return (reg2 % 65536) * 32'h0001_0001;
            default: return reg2;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp_blk
        int sz;
        bit flt;
        if (cmp_en && rst) begin
            sz  = m_size(mem_aluop_i);
            flt = (sz != 0) && ((mem_addr_i % sz) != 0);
            chk("pc_pass", mem2wb_pc, mem_pc_i);
            chk("wd_pass", mem_wd, wd_i);
            chk("hilo_pass", {mem_whilo, mem_hi ^ mem_lo}, {whilo_i, hi_i ^ lo_i});
            chk("hi_pass", mem_hi, hi_i);
            chk("cp0_pass", {mem_cp0_reg_we, mem_cp0_reg_write_addr}, {cp0_we_i, cp0_addr_i});
            chk("cp0_data_pass", mem_cp0_reg_data, cp0_data_i);
            chk("excepttype", mem_excepttype, !flt ? 0 : (m_store(mem_aluop_i) ? 2 : 1));
            chk("badvaddr", mem_badvaddr, flt ? mem_addr_i : 0);
            chk("wreg", mem_wreg, flt ? 0 : wreg_i);
            if (sz == 0) begin
                chk("nonmem_req", data_req, 0);
                chk("nonmem_stall", stallreq_mem, 0);
                chk("nonmem_wdata", mem_wdata, wdata_i);
            end
            if (flt) chk("fault_req", data_req, 0);
            if (data_req) begin
                chk("req_addr", data_addr, m_phys(mem_addr_i));
                chk("req_wr", data_wr, m_store(mem_aluop_i));
                if (m_store(mem_aluop_i)) begin
                    chk("req_wstrb", data_wstrb, m_strb(mem_aluop_i, mem_addr_i));
                    chk("req_wdata", data_wdata, m_wdata(mem_aluop_i, mem_reg2_i));
                end
            end
            if (sz != 0 && !m_store(mem_aluop_i) && model_loaded)
                chk("load_data", mem_wdata, m_load(mem_aluop_i, mem_addr_i, model_word));
            if (m_store(mem_aluop_i)) chk("store_wdata_pass", mem_wdata, wdata_i);
        end
    end

    // ---------------- drivers ----------------
    task automatic set_instr(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
        seq++;
        mem_aluop_i  = op;
        mem_addr_i   = addr;
        mem_reg2_i   = reg2;
        mem_pc_i     = 32'h0040_0000 + 32'(seq * 4);
        wd_i         = 5'(seq);
        wreg_i       = 1'b1;
        wdata_i      = 32'h5A5A_0000 + 32'(seq);
        whilo_i      = seq[0];
        hi_i         = 32'h1111_0000 + 32'(seq);
        lo_i         = 32'h2222_0000 + 32'(seq * 3);
        cp0_we_i     = seq[1];
        cp0_addr_i   = 5'(seq + 3);
        cp0_data_i   = 32'hC0C0_0000 + 32'(seq);
        model_loaded = 1'b0;
    endtask

    task automatic set_nop();
        set_instr(OP_NOP, 32'd0, 32'd0);
    endtask

    // Called just after a posedge. addr_ok is pulsed in cycle a, data_ok in
    // cycle d (d > a); stale adds an extra data_ok in cycle 0 (requires a > 0).
    task automatic run_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                              input int a, input int d, input logic [31:0] rd, input int hold,
                              input bit stale, input int exp_stall, input bit lit_en,
                              input logic [31:0] lit_val);
        int stall_cyc;
        int hs;
        bit reached;
        stall_cyc = 0;
        hs = 0;
        reached = 1'b0;
        set_instr(op, addr, reg2);
        for (int i = 0; i < 40 && !reached; i++) begin
            if (i == d + 1) begin
                model_loaded = 1'b1;
                model_word   = rd;
            end
            data_addr_ok = (i == a);
            data_data_ok = (i == d) || (stale && i == 0);
            data_rdata   = (i == d) ? rd : 32'hBAD0_BAD0;
            @(negedge clk);
            if (i == 0) begin
                first_addr  = data_addr;
                first_strb  = data_wstrb;
                first_wdata = data_wdata;
                first_wr    = data_wr;
            end
            if (stallreq_mem) stall_cyc++;
            if (data_req && data_addr_ok) hs++;
            if (i > d && !stallreq_mem) reached = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!reached) chk("access_timeout", 32'd0, 32'd1);
        chk("done_req", data_req, 0);
        if (lit_en) chk("load_literal", mem_wdata, lit_val);
        // Hold the completed access in MEM; the unit must not issue again.
        data_addr_ok = 1'b1;
        if (hold > 0) stall = 6'b010000;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (data_req && data_addr_ok) hs++;
            chk("hold_stallreq", stallreq_mem, 0);
            if (lit_en) chk("hold_literal", mem_wdata, lit_val);
        end
        stall = 6'b000000;
        chk("stall_cycles", stall_cyc, exp_stall);
        chk("handshakes", hs, 1);
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        set_nop();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        stall = 6'b0;
        flush = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'd0;
        set_nop();

        // Reset: outputs quiet, even with a load presented.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", data_req, 0);
        chk("rst_stall", stallreq_mem, 0);
        chk("rst_exc", mem_excepttype, 0);
        chk("rst_badva", mem_badvaddr, 0);
        set_instr(OP_LW, 32'h8000_0010, 32'd0);
        @(negedge clk);
        chk("rst_req_gated", data_req, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cmp_en = 1'b1;

        // LW, accept one cycle late, response two cycles after the request, held in DONE 3 cycles.
        run_access(OP_LW, 32'h8000_0010, 32'd0, 1, 2, 32'hDEAD_BEEF, 3, 1'b0, 3, 1'b1, 32'hDEAD_BEEF);
        chk("lw_addr", first_addr, 32'h0000_0010);
        chk("lw_wr", first_wr, 0);

        // Loads: byte/half extraction and extension.
        run_access(OP_LB,  32'h8000_0103, 32'd0, 0, 1, 32'h80FF_0000, 0, 1'b0, 1, 1'b1, 32'hFFFF_FF80);
        run_access(OP_LBU, 32'h8000_0103, 32'd0, 0, 1, 32'h80FF_0000, 0, 1'b0, 1, 1'b1, 32'h0000_0080);
        run_access(OP_LH,  32'h8000_0102, 32'd0, 0, 1, 32'h80FF_0000, 1, 1'b0, 1, 1'b1, 32'hFFFF_80FF);
        run_access(OP_LHU, 32'h0000_0102, 32'd0, 0, 2, 32'h80FF_0000, 0, 1'b0, 2, 1'b1, 32'h0000_80FF);

        // Stores: lane strobes and replication.
        run_access(OP_SH, 32'h0000_0202, 32'h1234_ABCD, 1, 3, 32'd0, 0, 1'b0, 4, 1'b0, 32'd0);
        chk("sh_strb", first_strb, 4'b1100);
        chk("sh_wdata", first_wdata, 32'hABCD_ABCD);
        chk("sh_wr", first_wr, 1);
        chk("sh_addr", first_addr, 32'h0000_0200);
        run_access(OP_SB, 32'hA000_0105, 32'h0000_00C3, 0, 1, 32'd0, 0, 1'b0, 1, 1'b0, 32'd0);
        chk("sb_strb", first_strb, 4'b0010);
        chk("sb_wdata", first_wdata, 32'hC3C3_C3C3);
        chk("sb_addr", first_addr, 32'h0000_0104);
        run_access(OP_SW, 32'hC000_0008, 32'hCAFE_F00D, 0, 2, 32'd0, 0, 1'b0, 2, 1'b0, 32'd0);
        chk("sw_addr_unmapped", first_addr, 32'hC000_0008);
        chk("sw_strb", first_strb, 4'b1111);

        // Alignment faults: no request even with addr_ok offered.
        set_instr(OP_LW, 32'h8000_0031, 32'd0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("adel_req", data_req, 0);
        chk("adel_exc", mem_excepttype, 2'b01);
        chk("adel_badva", mem_badvaddr, 32'h8000_0031);
        chk("adel_wreg", mem_wreg, 0);
        chk("adel_stall", stallreq_mem, 0);
        @(posedge clk);
        #1;
        set_instr(OP_SW, 32'h8000_0032, 32'h5555_AAAA);
        @(negedge clk);
        chk("ades_req", data_req, 0);
        chk("ades_exc", mem_excepttype, 2'b10);
        chk("ades_badva", mem_badvaddr, 32'h8000_0032);
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;

        // Non-memory op: straight pass-through.
        set_instr(OP_OR, 32'h8000_0040, 32'd0);
        @(negedge clk);
        chk("nm_req", data_req, 0);
        chk("nm_wdata", mem_wdata, 32'h5A5A_0000 + 32'(seq));
        @(posedge clk);
        #1;

        // Flush while waiting: response drained, next load issues only afterwards.
        set_instr(OP_LW, 32'h8000_0040, 32'd0);
        data_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wait_stall", stallreq_mem, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        set_instr(OP_LW, 32'h8000_0044, 32'd0);
        @(negedge clk);
        chk("drain_req", data_req, 0);
        chk("drain_stall", stallreq_mem, 1);
        @(posedge clk);
        #1;
        data_data_ok = 1'b1;
        data_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("drain_req2", data_req, 0);
        @(posedge clk);
        #1;
        data_data_ok = 1'b0;
        run_access(OP_LW, 32'h8000_0044, 32'd0, 0, 1, 32'h2222_2222, 0, 1'b0, 1, 1'b1, 32'h2222_2222);

        // Reset in WAIT: back to IDLE; a stale response afterwards is ignored.
        set_instr(OP_LW, 32'h8000_0020, 32'd0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("rma_req", data_req, 1);
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rma_req_low", data_req, 0);
        chk("rma_stall_low", stallreq_mem, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_access(OP_LW, 32'h8000_0024, 32'd0, 1, 2, 32'h3333_3333, 0, 1'b1, 3, 1'b1, 32'h3333_3333);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
